// File: rtl/truth_table_sequencer_if.sv
// Stimulus/capture bus between the truth-table sequencer and its controller.
// Define TT_CHECK_EN to add the expected-table input and mismatch outputs.
interface truth_table_sequencer_if #(
  parameter int VARS = 3
);
  logic                 start;
  logic                 y_in;
  logic [VARS-1:0]      vec;
  logic                 busy;
  logic                 done;
  logic [2**VARS-1:0]   tt;
`ifdef TT_CHECK_EN
  logic [2**VARS-1:0]   expected;
  logic                 mismatch;
  logic [VARS-1:0]      mismatch_idx;

  modport master (
    output start, y_in, expected,
    input  vec, busy, done, tt, mismatch, mismatch_idx
  );

  modport slave (
    input  start, y_in, expected,
    output vec, busy, done, tt, mismatch, mismatch_idx
  );
`else
  modport master (
    output start, y_in,
    input  vec, busy, done, tt
  );

  modport slave (
    input  start, y_in,
    output vec, busy, done, tt
  );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks every input combination of a VARS-input expression, holds each HOLD cycles,
// and packs the sampled outputs into tt. Define TT_CHECK_EN for expected-table checking.
module truth_table_sequencer #(
  parameter int VARS = 3,
  parameter int HOLD = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  truth_table_sequencer_if.slave  bus
);

  localparam int N  = 2**VARS;
  localparam int CW = $clog2(HOLD) + 1;

  localparam logic [VARS-1:0] VEC_LAST = VARS'(N - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t          state_q, state_n;
  logic [VARS-1:0] vec_q,   vec_n;
  logic [CW-1:0]   cnt_q,   cnt_n;
  logic            busy_q,  busy_n;
  logic            done_q,  done_n;
  logic [N-1:0]    tt_q,    tt_n;

`ifdef TT_CHECK_EN
  logic [N-1:0]    exp_q,   exp_n;
  logic            mm_q,    mm_n;
  logic [VARS-1:0] idx_q,   idx_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
`ifdef TT_CHECK_EN
      exp_q   <= '0;
      mm_q    <= 1'b0;
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      vec_q   <= vec_n;
      cnt_q   <= cnt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      tt_q    <= tt_n;
`ifdef TT_CHECK_EN
      exp_q   <= exp_n;
      mm_q    <= mm_n;
      idx_q   <= idx_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    cnt_n   = cnt_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    tt_n    = tt_q;
`ifdef TT_CHECK_EN
    exp_n   = exp_q;
    mm_n    = mm_q;
    idx_n   = idx_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_APPLY;
          busy_n  = 1'b1;
          vec_n   = '0;
          cnt_n   = '0;
          tt_n    = '0;
`ifdef TT_CHECK_EN
          exp_n   = bus.expected;
          mm_n    = 1'b0;
          idx_n   = '0;
`endif
        end
      end

      S_APPLY: begin
        // Sample on the HOLD-th cycle of the current vector; the last vector
        // exits straight to DONE so vec never wraps inside a run.
        if (cnt_q == CNT_LAST) begin
          tt_n[vec_q] = bus.y_in;
`ifdef TT_CHECK_EN
          if ((bus.y_in != exp_q[vec_q]) && !mm_q) begin
            mm_n  = 1'b1;
            idx_n = vec_q;
          end
`endif
          cnt_n = '0;
          if (vec_q == VEC_LAST) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            vec_n = vec_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.vec  = vec_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tt   = tt_q;
`ifdef TT_CHECK_EN
  assign bus.mismatch     = mm_q;
  assign bus.mismatch_idx = idx_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: HOLD=5 and HOLD=1 instances, randomized
// expressions, a queue of expected results per instance and a single checking monitor.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tt;
    int         busy;
`ifdef TT_CHECK_EN
    logic       mm;
    logic [2:0] idx;
`endif
  } exp_t;

  exp_t       exp_q [2][$];
  int         mode_s [2];
  logic [7:0] tbl_s  [2];
  logic       start_s[2];
  logic [2:0] vec_s  [2];
  logic       busy_s [2];
  logic       done_s [2];
  logic [7:0] tt_s   [2];
`ifdef TT_CHECK_EN
  logic [7:0] exp_in [2];
  logic       mm_s   [2];
  logic [2:0] idx_s  [2];
  int         fixed_ex = -1;
`endif

  int n_checks  = 0;
  int n_pass    = 0;
  int n_timeout = 0;
  logic end_req = 1'b0;

  // The downstream expression block: (a&b)|c, a^b^c, or an arbitrary table.
  function automatic logic y_of(input int m, input logic [7:0] t, input logic [2:0] v);
    case (m)
      0:       return (v[2] & v[1]) | v[0];
      1:       return v[2] ^ v[1] ^ v[0];
      default: return t[v];
    endcase
  endfunction

  function automatic logic [7:0] model_tt(input int m, input logic [7:0] t);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = y_of(m, t, 3'(i));
    return r;
  endfunction

  function automatic int hold_of(input int d);
    return (d == 0) ? 5 : 1;
  endfunction

  truth_table_sequencer_if #(.VARS(3)) if0 ();
  truth_table_sequencer_if #(.VARS(3)) if1 ();

  truth_table_sequencer #(.VARS(3), .HOLD(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  truth_table_sequencer #(.VARS(3), .HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  assign if0.start = start_s[0];
  assign if1.start = start_s[1];
  assign if0.y_in  = y_of(mode_s[0], tbl_s[0], if0.vec);
  assign if1.y_in  = y_of(mode_s[1], tbl_s[1], if1.vec);
  assign vec_s[0]  = if0.vec;
  assign vec_s[1]  = if1.vec;
  assign busy_s[0] = if0.busy;
  assign busy_s[1] = if1.busy;
  assign done_s[0] = if0.done;
  assign done_s[1] = if1.done;
  assign tt_s[0]   = if0.tt;
  assign tt_s[1]   = if1.tt;
`ifdef TT_CHECK_EN
  assign if0.expected = exp_in[0];
  assign if1.expected = exp_in[1];
  assign mm_s[0]  = if0.mismatch;
  assign mm_s[1]  = if1.mismatch;
  assign idx_s[0] = if0.mismatch_idx;
  assign idx_s[1] = if1.mismatch_idx;
`endif

  // ---------------- monitor / scoreboard ----------------
  int         busy_cnt [2];
  int         run_len  [2];
  int         bad_seq  [2];
  logic [2:0] prev_vec [2];
  logic       prev_done[2];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, req);
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("reset_outputs", d, 32'({vec_s[d], busy_s[d], done_s[d], tt_s[d]}), 32'd0);
`ifdef TT_CHECK_EN
        chk("reset_mismatch", d, 32'({mm_s[d], idx_s[d]}), 32'd0);
`endif
        exp_q[d].delete();
        busy_cnt[d]  = 0;
        run_len[d]   = 0;
        bad_seq[d]   = 0;
        prev_vec[d]  = '0;
        prev_done[d] = 1'b0;
      end
    end else if (end_req) begin
      for (int d = 0; d < 2; d++) chk("queue_drained", d, 32'(exp_q[d].size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
      $finish;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (busy_s[d]) begin
          busy_cnt[d]++;
          if (busy_cnt[d] == 1) begin
            if (vec_s[d] != 3'd0) bad_seq[d]++;
            run_len[d] = 1;
          end else if (vec_s[d] == prev_vec[d]) begin
            run_len[d]++;
          end else begin
            if ((run_len[d] != hold_of(d)) || (32'(vec_s[d]) != 32'(prev_vec[d]) + 1)) bad_seq[d]++;
            run_len[d] = 1;
          end
          prev_vec[d] = vec_s[d];
        end
        if (done_s[d]) begin
          chk("done_one_cycle", d, 32'(prev_done[d]), 32'd0);
          if (!prev_done[d]) begin
            if (exp_q[d].size() == 0) begin
              chk("unexpected_done", d, 32'd1, 32'd0);
            end else begin
              exp_t e;
              e = exp_q[d].pop_front();
              chk("tt", d, 32'(tt_s[d]), 32'(e.tt));
              chk("busy_cycles", d, 32'(busy_cnt[d]), 32'(e.busy));
              chk("vec_at_done", d, 32'(vec_s[d]), 32'd7);
              chk("busy_at_done", d, 32'(busy_s[d]), 32'd0);
              chk("vec_hold_pattern", d, 32'(bad_seq[d] + ((run_len[d] != hold_of(d)) ? 1 : 0)), 32'd0);
`ifdef TT_CHECK_EN
              chk("mismatch", d, 32'(mm_s[d]), 32'(e.mm));
              chk("mismatch_idx", d, 32'(idx_s[d]), 32'(e.idx));
`endif
            end
            busy_cnt[d] = 0;
            run_len[d]  = 0;
            bad_seq[d]  = 0;
          end
        end
        prev_done[d] = done_s[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_exp(input int d, input int m, input logic [7:0] t);
    exp_t e;
    mode_s[d] = m;
    tbl_s[d]  = t;
    e.tt   = model_tt(m, t);
    e.busy = 8 * hold_of(d);
`ifdef TT_CHECK_EN
    if (fixed_ex >= 0) exp_in[d] = 8'(fixed_ex);
    else exp_in[d] = ($urandom_range(0, 1) == 1) ? e.tt : e.tt ^ 8'($urandom);
    e.mm  = (e.tt != exp_in[d]);
    e.idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (e.tt[i] != exp_in[d][i]) e.idx = 3'(i);
`endif
    exp_q[d].push_back(e);
  endtask

  task automatic wait_done(input int d, input int limit);
    logic found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_s[d]) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_timeout++;
      $display("FAIL done_timeout dut%0d: got no done expected done within %0d cycles", d, limit);
    end
  endtask

  task automatic pulse_start(input int d);
    @(posedge clk) #1 start_s[d] = 1'b1;
    @(posedge clk) #1 start_s[d] = 1'b0;
  endtask

  task automatic run_one(input int d, input int m, input logic [7:0] t);
    push_exp(d, m, t);
    pulse_start(d);
    wait_done(d, 8 * hold_of(d) + 10);
  endtask

  initial begin
    mode_s  = '{0, 0};
    tbl_s   = '{8'h00, 8'h00};
    start_s = '{1'b1, 1'b1};
`ifdef TT_CHECK_EN
    exp_in  = '{8'h00, 8'h00};
`endif
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    start_s = '{1'b0, 1'b0};
    #2 rst_n = 1'b1;

    run_one(0, 0, 8'h00);
    run_one(1, 0, 8'h00);

`ifdef TT_CHECK_EN
    fixed_ex = 8'hEB;
    run_one(0, 0, 8'h00);
    fixed_ex = 8'hEA;
    run_one(0, 0, 8'h00);
    fixed_ex = -1;
`endif

    // start held across a whole run: exactly one relaunch after DONE
    push_exp(0, 1, 8'h00);
    push_exp(0, 1, 8'h00);
    @(posedge clk) #1 start_s[0] = 1'b1;
    wait_done(0, 60);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (busy_s[0]) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_timeout++;
        $display("FAIL relaunch_timeout dut0: got busy=0 expected busy=1");
      end
    end
    start_s[0] = 1'b0;
    wait_done(0, 60);

    // asynchronous reset mid-run while vec==3, then a clean run
    push_exp(0, 0, 8'h00);
    pulse_start(0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (vec_s[0] == 3'd3) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_timeout++;
        $display("FAIL vec3_timeout dut0: got vec=%0d expected 3", vec_s[0]);
      end
    end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_one(0, 0, 8'h00);

    for (int k = 0; k < 10; k++) begin
      run_one(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 8'($urandom));
    end

    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected end before 200000 time units");
    $fatal(1);
  end

endmodule
